// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, clear request and status flags.
// Each packed field holds one slice per port, with port i at [i*W +: W].
interface regfile_mp_if #(
  parameter int unsigned DW  = 128,
  parameter int unsigned AW  = 7,
  parameter int unsigned NWR = 2,
  parameter int unsigned NRD = 6
);
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              init_start;
  logic              busy;
  logic              wr_conflict;
  logic              wr_oob;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, init_start,
    input  rd_data, busy, wr_conflict, wr_oob
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, init_start,
    output rd_data, busy, wr_conflict, wr_oob
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a hardware clear sequencer, highest-port-wins write arbitration
// and registered conflict/out-of-range flags. Optional feature macro: RF_BYPASS_EN (write-to-read bypass).
module regfile_mp #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned NWR   = 2,
  parameter int unsigned NRD   = 6
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            busy_q, busy_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            wr_oob_q, wr_oob_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic [NWR-1:0]  wr_fire_c;
  logic            conflict_c;
  logic            oob_c;
  logic            clr_last_c;
  logic [NRD*DW-1:0] rd_data_c;

  assign clr_last_c = (clr_ptr_q == AW'(DEPTH - 1));

  // Per-port write qualification and same-cycle hazard detection (IDLE only).
  always_comb begin
    wr_fire_c  = '0;
    conflict_c = 1'b0;
    oob_c      = 1'b0;
    if (state_q == S_IDLE) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p]) begin
          if (32'(bus.wr_addr[p*AW +: AW]) < DEPTH) wr_fire_c[p] = 1'b1;
          else                                      oob_c        = 1'b1;
          for (int q = p + 1; q < NWR; q++) begin
            if (bus.wr_en[q] && (bus.wr_addr[q*AW +: AW] == bus.wr_addr[p*AW +: AW]))
              conflict_c = 1'b1;
          end
        end
      end
      for (int i = 0; i < NRD; i++) begin
        if (32'(bus.rd_addr[i*AW +: AW]) >= DEPTH) oob_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      clr_ptr_q     <= '0;
      busy_q        <= 1'b1;
      wr_conflict_q <= 1'b0;
      wr_oob_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
      wr_oob_q      <= wr_oob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: if (clr_last_c)     state_d = S_IDLE;
      S_IDLE:  if (bus.init_start) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  // Pointer rests at zero in IDLE, so a new clear always starts from row 0.
  always_comb begin
    clr_ptr_d     = '0;
    busy_d        = (state_d == S_CLEAR);
    wr_conflict_d = conflict_c;
    wr_oob_d      = oob_c;
    if (state_q == S_CLEAR && !clr_last_c) clr_ptr_d = clr_ptr_q + AW'(1);
  end

  // Storage has no reset; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_fire_c[p]) mem_q[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*DW +: DW];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (state_q == S_IDLE) begin
      for (int i = 0; i < NRD; i++) begin
        if (32'(bus.rd_addr[i*AW +: AW]) < DEPTH)
          rd_data_c[i*DW +: DW] = mem_q[bus.rd_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (wr_fire_c[p] && (bus.wr_addr[p*AW +: AW] == bus.rd_addr[i*AW +: AW]))
            rd_data_c[i*DW +: DW] = bus.wr_data[p*DW +: DW];
        end
`endif
      end
    end
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.wr_oob      = wr_oob_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: clear timing, writes, arbitration, bypass,
// out-of-range handling on a DEPTH=100 instance, and clear restart via init_start and reset.
module tb_regfile_mp;
  localparam int unsigned DW      = 128;
  localparam int unsigned AW      = 7;
  localparam int unsigned NWR     = 2;
  localparam int unsigned NRD     = 6;
  localparam int unsigned DEPTH   = 128;
  localparam int unsigned DEPTH_S = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.DW(DW), .AW(AW), .NWR(NWR), .NRD(NRD)) bus   ();
  regfile_mp_if #(.DW(DW), .AW(AW), .NWR(NWR), .NRD(NRD)) bus_s ();

  regfile_mp #(.DW(DW), .DEPTH(DEPTH),   .AW(AW), .NWR(NWR), .NRD(NRD)) dut   (.clk(clk), .reset(reset), .bus(bus));
  regfile_mp #(.DW(DW), .DEPTH(DEPTH_S), .AW(AW), .NWR(NWR), .NRD(NRD)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = '0;   bus.wr_addr = '0;   bus.wr_data = '0;   bus.rd_addr = '0;   bus.init_start = 1'b0;
    bus_s.wr_en = '0; bus_s.wr_addr = '0; bus_s.wr_data = '0; bus_s.rd_addr = '0; bus_s.init_start = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    bus.wr_en[p] = 1'b1;
    bus.wr_addr[p*AW +: AW] = AW'(a);
    bus.wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_wr_s(input int p, input int a, input logic [DW-1:0] d);
    bus_s.wr_en[p] = 1'b1;
    bus_s.wr_addr[p*AW +: AW] = AW'(a);
    bus_s.wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    bus.rd_addr[i*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return bus.rd_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_s(input int i);
    return bus_s.rd_data[i*DW +: DW];
  endfunction

  // Counts edges until busy drops, bounded so a stuck sequencer still reaches the summary.
  task automatic count_busy(input string tag);
    int n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  task automatic check_all_zero(input string tag);
    for (int base = 0; base < int'(DEPTH); base += NRD) begin
      for (int i = 0; i < int'(NRD); i++) set_rd(i, (base + i) % int'(DEPTH));
      #1;
      for (int i = 0; i < int'(NRD); i++)
        if (base + i < int'(DEPTH)) check($sformatf("%s[%0d]", tag, base + i), rd(i), '0);
    end
    bus.rd_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    check("rst_busy",     DW'(bus.busy),        DW'(1));
    check("rst_conflict", DW'(bus.wr_conflict), DW'(0));
    check("rst_oob",      DW'(bus.wr_oob),      DW'(0));
    check("rst_busy_s",   DW'(bus_s.busy),      DW'(1));

    // Writes held throughout the clear must leave nothing behind.
    set_wr(0, 7, 128'hDEAD);
    set_wr(1, 8, 128'hBEEF);
    set_rd(0, 7);
    reset = 1'b0;
    #1;
    check("clear_rd_zero", rd(0), '0);
    count_busy("busy_len_reset");
    idle_inputs();
    check("busy_s_done",    DW'(bus_s.busy),        DW'(0));
    check("clear_conflict", DW'(bus.wr_conflict),   DW'(0));
    check_all_zero("post_reset_zero");

    // Two ports, distinct addresses.
    set_wr(0, 5, 128'h333);
    set_wr(1, 9, 128'h666);
    tick();
    idle_inputs();
    set_rd(0, 5);
    set_rd(1, 9);
    #1;
    check("wr_p0_reg5", rd(0), 128'h333);
    check("wr_p1_reg9", rd(1), 128'h666);
    check("no_conflict", DW'(bus.wr_conflict), DW'(0));

    // Same address: port 1 wins, flag for one cycle.
    set_wr(0, 12, 128'hAA);
    set_wr(1, 12, 128'hBB);
    tick();
    idle_inputs();
    set_rd(0, 12);
    #1;
    check("conflict_set", DW'(bus.wr_conflict), DW'(1));
    check("arb_reg12",    rd(0), 128'hBB);
    tick();
    check("conflict_clr", DW'(bus.wr_conflict), DW'(0));

    // Read-during-write of reg 3.
    set_wr(0, 3, 128'h11);
    tick();
    idle_inputs();
    set_wr(0, 3, 128'h22);
    set_rd(0, 3);
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_same_cycle", rd(0), 128'h22);
`else
    check("rdw_same_cycle", rd(0), 128'h11);
`endif
    tick();
    idle_inputs();
    set_rd(0, 3);
    #1;
    check("rdw_next_cycle", rd(0), 128'h22);

    // Dual write to a cleared reg while reading it.
    set_wr(0, 20, 128'h1);
    set_wr(1, 20, 128'h2);
    set_rd(0, 20);
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_prio", rd(0), 128'h2);
`else
    check("bypass_prio", rd(0), 128'h0);
`endif
    tick();
    idle_inputs();
    check("conflict_reg20", DW'(bus.wr_conflict), DW'(1));

    // DEPTH=100: out-of-range write dropped, boundary row kept, oob flag pulses.
    set_wr_s(0, 110, 128'h55);
    set_wr_s(1, 99,  128'h99);
    tick();
    idle_inputs();
    check("oob_wr_flag",  DW'(bus_s.wr_oob), DW'(1));
    check("oob_big_quiet", DW'(bus.wr_oob),  DW'(0));
    bus_s.rd_addr[0*AW +: AW] = AW'(110);
    bus_s.rd_addr[1*AW +: AW] = AW'(99);
    #1;
    check("oob_rd_zero", rd_s(0), '0);
    check("rd_row99",    rd_s(1), 128'h99);
    tick();
    check("oob_rd_flag", DW'(bus_s.wr_oob), DW'(1));
    idle_inputs();
    tick();
    check("oob_clr", DW'(bus_s.wr_oob), DW'(0));

    // Fill every register, then clear on request.
    for (int a = 0; a < int'(DEPTH); a += 2) begin
      set_wr(0, a,     DW'(32'h1000 + a));
      set_wr(1, a + 1, DW'(32'h1000 + a + 1));
      tick();
    end
    idle_inputs();
    set_rd(0, 0);
    set_rd(1, 127);
    set_rd(2, 64);
    #1;
    check("fill_reg0",   rd(0), 128'h1000);
    check("fill_reg127", rd(1), 128'h107F);
    check("fill_reg64",  rd(2), 128'h1040);
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    check("init_busy", DW'(bus.busy), DW'(1));
    count_busy("busy_len_init");
    check_all_zero("post_init_zero");

    // Reset at clear cycle 40 restarts the full sequence.
    set_wr(0, 100, 128'h77);
    tick();
    idle_inputs();
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    repeat (39) tick();
    check("mid_clear_busy", DW'(bus.busy), DW'(1));
    reset = 1'b1;
    #1;
    check("abort_busy", DW'(bus.busy), DW'(1));
    tick();
    reset = 1'b0;
    count_busy("busy_len_abort");
    set_rd(0, 100);
    set_rd(1, 5);
    #1;
    check("abort_reg100", rd(0), '0);
    check("abort_reg5",   rd(1), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
